mips_multicycle_ctrl: RTL and testbench
=======================================

// Module: mips_multicycle_ctrl
// PURPOSE
//  Control unit of the multicycle MIPS core; drives the 3-bit ALU control bus (and/or/add/sub/slt) and consumes ALU zero.
//  Moore FSM sequences FETCH..WB per instruction; branch PC enable is the only output that depends on zero.
//  Sits between the instruction register (op/funct) and the datapath muxes/enables.
// PARAMETERS
//  none; encodings fixed: lw 100011, sw 101011, R 000000, beq 000100, addi 001000, j 000010, bne 000101
// PORTS
//  clk          in   1  rising-edge clock, single domain
//  reset_n      in   1  asynchronous, active-low reset
//  op           in   6  IR[31:26]
//  funct        in   6  IR[5:0]
//  zero         in   1  ALU zero flag (same cycle)
//  irwrite      out  1  load instruction register
//  memwrite     out  1  data memory write
//  regwrite     out  1  register file write
//  pcen         out  1  PC load = pcwrite | (branch & taken)
//  iord         out  1  0=PC, 1=ALUOut as memory address
//  regdst       out  1  0=rt, 1=rd
//  memtoreg     out  1  0=ALUOut, 1=Data
//  alusrca      out  1  0=PC, 1=A
//  alusrcb      out  2  00=B, 01=4, 10=SignImm, 11=SignImm<<2
//  pcsrc        out  2  00=ALUResult, 01=ALUOut, 10=jump target
//  alucontrol   out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
//  illegal      out  1  1-cycle flag: unsupported op (DECODE) or funct (RTYPEEX)
//  state        out  4  current state, debug
// BEHAVIOUR
//  States (4b): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, RTYPEWB 7, BEQEX 8, ADDIEX 9, ADDIWB 10, JEX 11, BNEEX 12.
//  Reset: state<=FETCH asynchronously; while reset_n=0 irwrite/memwrite/regwrite/pcen/illegal forced 0; other outputs = FETCH values.
//  Unlisted outputs are 0 in every state; alucontrol defaults to 010.
//  FETCH: iord=0 alusrca=0 alusrcb=01 add pcsrc=00 irwrite=1 pcwrite=1 -> DECODE.
//  DECODE: alusrca=0 alusrcb=11 add (branch target to ALUOut). lw/sw->MEMADR, R->RTYPEEX, beq->BEQEX, addi->ADDIEX, j->JEX, else illegal=1 -> FETCH.
//  MEMADR: alusrca=1 alusrcb=10 add; lw->MEMRD, sw->MEMWR. MEMRD: iord=1 -> MEMWB. MEMWB: regdst=0 memtoreg=1 regwrite=1 -> FETCH.
//  MEMWR: iord=1 memwrite=1 -> FETCH.
//  RTYPEEX: alusrca=1 alusrcb=00; funct 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt -> RTYPEWB; other funct: illegal=1, -> FETCH, no writeback.
//  RTYPEWB: regdst=1 memtoreg=0 regwrite=1 -> FETCH.
//  BEQEX: alusrca=1 alusrcb=00 sub pcsrc=01; pcen=zero (same cycle, combinational) -> FETCH.
//  ADDIEX: alusrca=1 alusrcb=10 add -> ADDIWB. ADDIWB: regdst=0 memtoreg=0 regwrite=1 -> FETCH.
//  JEX: pcsrc=10 pcwrite=1 -> FETCH.
//  Latencies (cycles incl. FETCH): lw 5, sw 4, R 4, addi 4, beq 3, j 3, bne 3, illegal 2.
//  op/funct sampled only in DECODE/MEMADR/RTYPEEX; IR is stable there (irwrite only in FETCH).
//  Unreachable state encodings (13-15) -> FETCH next cycle, all enables 0.
//  Reset mid-instruction: abort immediately, no pending write completes; resume at FETCH on first edge after release.
// CONFIGURATION
//  MC_BNE_EN defined: DECODE op 000101 -> BNEEX; BNEEX = BEQEX except pcen=~zero.
//  MC_BNE_EN undefined: op 000101 is illegal (illegal=1 in DECODE, -> FETCH); BNEEX never entered.
// TESTING
//  reset_n low mid-MEMWB (regwrite=1) -> regwrite drops same cycle; after release state=0, irwrite=pcen=1.
//  op=100011 -> states 0,1,2,3,4; MEMRD iord=1; MEMWB regwrite=1 memtoreg=1 regdst=0; back to 0.
//  op=0 funct=101010 -> RTYPEEX alucontrol=111 alusrca=1 alusrcb=00; RTYPEWB regwrite=1 regdst=1.
//  op=000100 zero=1 -> BEQEX pcen=1 pcsrc=01 alucontrol=110; repeat zero=0 -> pcen=0; toggle zero in-cycle -> pcen tracks.
//  op=111111 -> DECODE illegal=1 all writes 0, next state 0; op=0 funct=000000 -> illegal in RTYPEEX, no regwrite.
//  op=000101 zero=0: MC_BNE_EN set -> BNEEX pcen=1; unset -> illegal=1 in DECODE, 2-cycle return to FETCH.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control unit: Moore FSM that sequences FETCH..writeback and drives datapath muxes/enables.
// Optional build macro MC_BNE_EN adds the BNEEX state (bne branches when zero is clear).
module mips_multicycle_ctrl (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic       pcen,
  output logic       iord,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11,
    S_BNEEX   = 4'd12
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
`ifdef MC_BNE_EN
  localparam logic [5:0] OP_BNE  = 6'b000101;
`endif

  state_t state_r;
  state_t next_state_s;
  logic   irwrite_s;
  logic   memwrite_s;
  logic   regwrite_s;
  logic   pcwrite_s;
  logic   branch_s;
  logic   taken_s;
  logic   illegal_s;

  // State register; reset aborts any instruction in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and Moore outputs; only the branch-taken term looks at zero.
  always_comb begin
    next_state_s = S_FETCH;
    irwrite_s    = 1'b0;
    memwrite_s   = 1'b0;
    regwrite_s   = 1'b0;
    pcwrite_s    = 1'b0;
    branch_s     = 1'b0;
    taken_s      = 1'b0;
    illegal_s    = 1'b0;
    iord         = 1'b0;
    regdst       = 1'b0;
    memtoreg     = 1'b0;
    alusrca      = 1'b0;
    alusrcb      = 2'b00;
    pcsrc        = 2'b00;
    alucontrol   = 3'b010;
    case (state_r)
      S_FETCH: begin
        alusrcb      = 2'b01;
        irwrite_s    = 1'b1;
        pcwrite_s    = 1'b1;
        next_state_s = S_DECODE;
      end
      S_DECODE: begin
        // Precompute the branch target into ALUOut while the opcode is decoded.
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: next_state_s = S_MEMADR;
          OP_R:         next_state_s = S_RTYPEEX;
          OP_BEQ:       next_state_s = S_BEQEX;
          OP_ADDI:      next_state_s = S_ADDIEX;
          OP_J:         next_state_s = S_JEX;
`ifdef MC_BNE_EN
          OP_BNE:       next_state_s = S_BNEEX;
`endif
          default: begin
            illegal_s    = 1'b1;
            next_state_s = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        case (op)
          OP_LW:   next_state_s = S_MEMRD;
          OP_SW:   next_state_s = S_MEMWR;
          default: next_state_s = S_FETCH;
        endcase
      end
      S_MEMRD: begin
        iord         = 1'b1;
        next_state_s = S_MEMWB;
      end
      S_MEMWB: begin
        memtoreg   = 1'b1;
        regwrite_s = 1'b1;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        memwrite_s = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca      = 1'b1;
        next_state_s = S_RTYPEWB;
        case (funct)
          6'b100000: alucontrol = 3'b010;
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default: begin
            illegal_s    = 1'b1;
            next_state_s = S_FETCH;
          end
        endcase
      end
      S_RTYPEWB: begin
        regdst     = 1'b1;
        regwrite_s = 1'b1;
      end
      S_BEQEX: begin
        alusrca    = 1'b1;
        alucontrol = 3'b110;
        pcsrc      = 2'b01;
        branch_s   = 1'b1;
        taken_s    = zero;
      end
      S_ADDIEX: begin
        alusrca      = 1'b1;
        alusrcb      = 2'b10;
        next_state_s = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite_s = 1'b1;
      end
      S_JEX: begin
        pcsrc     = 2'b10;
        pcwrite_s = 1'b1;
      end
`ifdef MC_BNE_EN
      S_BNEEX: begin
        alusrca    = 1'b1;
        alucontrol = 3'b110;
        pcsrc      = 2'b01;
        branch_s   = 1'b1;
        taken_s    = ~zero;
      end
`endif
      default: next_state_s = S_FETCH;
    endcase
  end

  // Enables are squashed while reset is held so nothing half-finished gets written.
  assign irwrite  = irwrite_s & reset_n;
  assign memwrite = memwrite_s & reset_n;
  assign regwrite = regwrite_s & reset_n;
  assign pcen     = (pcwrite_s | (branch_s & taken_s)) & reset_n;
  assign illegal  = illegal_s & reset_n;
  assign state    = state_r;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: instruction-level model plus directed literal checks.
module tb_mips_multicycle_ctrl;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [5:0] op = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  logic       irwrite, memwrite, regwrite, pcen, iord, regdst, memtoreg, alusrca, illegal;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;

  int n_chk = 0;
  int n_fail = 0;
  int exp_q[$];

  mips_multicycle_ctrl dut (
    .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .zero(zero),
    .irwrite(irwrite), .memwrite(memwrite), .regwrite(regwrite), .pcen(pcen),
    .iord(iord), .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol),
    .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  // Packed view: irwrite memwrite regwrite pcen iord regdst memtoreg alusrca alusrcb pcsrc alucontrol illegal
  logic [15:0] dut_word;
  assign dut_word = {irwrite, memwrite, regwrite, pcen, iord, regdst, memtoreg, alusrca,
                     alusrcb, pcsrc, alucontrol, illegal};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic bit legal_funct(input logic [5:0] f);
    return (f == 6'b100000) || (f == 6'b100010) || (f == 6'b100100) ||
           (f == 6'b100101) || (f == 6'b101010);
  endfunction

  function automatic bit bne_on();
`ifdef MC_BNE_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Control word each state must show, straight from the per-state output table.
  function automatic logic [15:0] model(input int st, input logic [5:0] o, input logic [5:0] f,
                                        input logic z);
    logic wi, wm, wr, pe, io, rd, mr, sa, ill;
    logic [1:0] sb, ps;
    logic [2:0] ac;
    {wi, wm, wr, pe, io, rd, mr, sa, ill} = 9'd0;
    sb = 2'b00; ps = 2'b00; ac = 3'b010;
    case (st)
      0:  begin sb = 2'b01; wi = 1'b1; pe = 1'b1; end
      1:  begin
            sb = 2'b11;
            ill = !(o == 6'b100011 || o == 6'b101011 || o == 6'b000000 || o == 6'b000100 ||
                    o == 6'b001000 || o == 6'b000010 || (o == 6'b000101 && bne_on()));
          end
      2:  begin sa = 1'b1; sb = 2'b10; end
      3:  io = 1'b1;
      4:  begin mr = 1'b1; wr = 1'b1; end
      5:  begin io = 1'b1; wm = 1'b1; end
      6:  begin
            sa = 1'b1;
            case (f)
              6'b100010: ac = 3'b110;
              6'b100100: ac = 3'b000;
              6'b100101: ac = 3'b001;
              6'b101010: ac = 3'b111;
              default:   ac = 3'b010;
            endcase
            ill = !legal_funct(f);
          end
      7:  begin rd = 1'b1; wr = 1'b1; end
      8:  begin sa = 1'b1; ac = 3'b110; ps = 2'b01; pe = z; end
      9:  begin sa = 1'b1; sb = 2'b10; end
      10: wr = 1'b1;
      11: begin ps = 2'b10; pe = 1'b1; end
      12: begin sa = 1'b1; ac = 3'b110; ps = 2'b01; pe = ~z; end
      default: ;
    endcase
    return {wi, wm, wr, pe, io, rd, mr, sa, sb, ps, ac, ill};
  endfunction

  // Expected state walk for one instruction, derived from its latency class.
  task automatic push_seq(input logic [5:0] o, input logic [5:0] f, output int n);
    int seq[$];
    seq = '{0, 1};
    case (o)
      6'b100011: seq = '{0, 1, 2, 3, 4};
      6'b101011: seq = '{0, 1, 2, 5};
      6'b000000: seq = legal_funct(f) ? '{0, 1, 6, 7} : '{0, 1, 6};
      6'b000100: seq = '{0, 1, 8};
      6'b001000: seq = '{0, 1, 9, 10};
      6'b000010: seq = '{0, 1, 11};
      6'b000101: if (bne_on()) seq = '{0, 1, 12};
      default: ;
    endcase
    foreach (seq[i]) exp_q.push_back(seq[i]);
    n = seq.size();
  endtask

  // Single compare process: mid-cycle, check state and controls against the model.
  always @(negedge clk) begin
    int s;
    if (reset_n && exp_q.size() > 0) begin
      s = exp_q.pop_front();
      check("state", {28'd0, state}, s);
      check($sformatf("ctrl_st%0d_op%0h", s, op), {16'd0, dut_word}, {16'd0, model(s, op, funct, zero)});
    end
  end

  // Called 1 ns after a rising edge with the DUT in FETCH; returns the same way.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z);
    int n;
    op = o; funct = f; zero = z;
    push_seq(o, f, n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #12;
    check("rst_state", {28'd0, state}, 32'd0);
    check("rst_irwrite", {31'd0, irwrite}, 32'd0);
    check("rst_pcen", {31'd0, pcen}, 32'd0);
    check("rst_alusrcb", {30'd0, alusrcb}, 32'd1);
    check("rst_alucontrol", {29'd0, alucontrol}, 32'd2);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
    check("rel_irwrite", {31'd0, irwrite}, 32'd1);
    check("rel_pcen", {31'd0, pcen}, 32'd1);

    run_instr(6'b100011, 6'd0, 1'b0);
    run_instr(6'b101011, 6'd0, 1'b1);
    run_instr(6'b000000, 6'b100000, 1'b0);
    run_instr(6'b000000, 6'b100010, 1'b0);
    run_instr(6'b000000, 6'b100100, 1'b1);
    run_instr(6'b000000, 6'b100101, 1'b0);
    run_instr(6'b000000, 6'b101010, 1'b0);
    run_instr(6'b000000, 6'b000000, 1'b0);
    run_instr(6'b000100, 6'd0, 1'b1);
    run_instr(6'b000100, 6'd0, 1'b0);
    run_instr(6'b001000, 6'd0, 1'b0);
    run_instr(6'b000010, 6'd0, 1'b0);
    run_instr(6'b000101, 6'd0, 1'b0);
    run_instr(6'b000101, 6'd0, 1'b1);
    run_instr(6'b111111, 6'd0, 1'b0);

    // slt walk with hand-written values
    op = 6'b000000; funct = 6'b101010; zero = 1'b0;
    step();
    step();
    check("slt_state", {28'd0, state}, 32'd6);
    check("slt_alucontrol", {29'd0, alucontrol}, 32'd7);
    check("slt_alusrca", {31'd0, alusrca}, 32'd1);
    check("slt_alusrcb", {30'd0, alusrcb}, 32'd0);
    step();
    check("slt_wb_regwrite", {31'd0, regwrite}, 32'd1);
    check("slt_wb_regdst", {31'd0, regdst}, 32'd1);
    step();
    check("slt_back", {28'd0, state}, 32'd0);

    // beq with zero toggled inside the execute cycle
    op = 6'b000100; zero = 1'b0;
    step();
    step();
    check("beq_state", {28'd0, state}, 32'd8);
    check("beq_pcen_z0", {31'd0, pcen}, 32'd0);
    zero = 1'b1;
    #1;
    check("beq_pcen_z1", {31'd0, pcen}, 32'd1);
    check("beq_pcsrc", {30'd0, pcsrc}, 32'd1);
    check("beq_alucontrol", {29'd0, alucontrol}, 32'd6);
    zero = 1'b0;
    #1;
    check("beq_pcen_back0", {31'd0, pcen}, 32'd0);
    step();
    check("beq_back", {28'd0, state}, 32'd0);

    // unsupported opcode
    op = 6'b111111;
    step();
    check("ill_flag", {31'd0, illegal}, 32'd1);
    check("ill_writes", {28'd0, irwrite, memwrite, regwrite, pcen}, 32'd0);
    step();
    check("ill_back", {28'd0, state}, 32'd0);

    // bne, build-dependent
    op = 6'b000101; zero = 1'b0;
    step();
    check("bne_decode_illegal", {31'd0, illegal}, bne_on() ? 32'd0 : 32'd1);
    step();
    if (bne_on()) begin
      check("bne_state", {28'd0, state}, 32'd12);
      check("bne_pcen", {31'd0, pcen}, 32'd1);
      step();
    end
    check("bne_back", {28'd0, state}, 32'd0);

    // reset asserted during load writeback
    op = 6'b100011; zero = 1'b0;
    repeat (4) step();
    check("mwb_state", {28'd0, state}, 32'd4);
    check("mwb_regwrite", {31'd0, regwrite}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("rstmid_regwrite", {31'd0, regwrite}, 32'd0);
    check("rstmid_state", {28'd0, state}, 32'd0);
    check("rstmid_enables", {27'd0, irwrite, memwrite, pcen, illegal, regwrite}, 32'd0);
    op = 6'b111111;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("rstrel_state", {28'd0, state}, 32'd0);
    check("rstrel_irwrite", {31'd0, irwrite}, 32'd1);
    check("rstrel_pcen", {31'd0, pcen}, 32'd1);
    step();
    check("rstrel_decode", {28'd0, state}, 32'd1);
    step();
    check("rstrel_fetch", {28'd0, state}, 32'd0);

    run_instr(6'b001000, 6'd0, 1'b1);
    run_instr(6'b100011, 6'd0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
